frame_config_sequencer: RTL and testbench
=========================================

// Module: frame_config_sequencer
// PURPOSE
//  Bitstream-to-frame sequencer for the fabric configuration chain.
//  - Consumes a 32-bit word stream; hunts for a sync word; parses frame packets.
//  - Drives the row-wide FrameData bus and pulses exactly one FrameStrobe bit per
//    packet, at (column, frame), for the tiles of the addressed column.
//  - Columns whose tiles have NoConfigBits=0, such as terminator tiles, may still be
//    addressed; their strobes are simply left unconnected.
// PARAMETERS
//  MaxFramesPerCol  20            frames per column; must be <= 32
//  FrameBitsPerRow  32            bits per row per frame; fixed at 32, equal to the stream width
//  NumRows          16            tile rows; data words per packet
//  NumColumns       16            tile columns; must be <= 256
//  SYNC_WORD        32'hFAB0_FAB1 stream sync pattern
// PORTS
//  CLK          in   1                               fabric config clock; all logic on rising edge
//  RESET        in   1                               synchronous, active-high reset
//  WriteData    in   32                              stream word
//  WriteStrobe  in   1                               word valid
//  Ready        out  1                               word accepted when WriteStrobe && Ready
//  FrameData    out  NumRows*FrameBitsPerRow         row r at [r*32 +: 32]
//  FrameStrobe  out  NumColumns*MaxFramesPerCol      bit index = col*MaxFramesPerCol + frame
//  ConfigBusy   out  1                               high in any state except IDLE
//  ConfigDone   out  1                               sticky; set on desync, cleared on sync
//  ConfigError  out  1                               sticky; set on a bad packet, cleared on sync
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 except Ready=1; state = IDLE.
//  - RESET asserted mid-packet aborts the packet: no strobe is issued and FrameData is cleared.
//  States
//  - IDLE: Ready=1. Accepting SYNC_WORD -> HEADER; clears ConfigDone and ConfigError.
//    All other words are discarded.
//  - HEADER: Ready=1. Word fields: [31] desync, [19:12] col, [4:0] frame.
//    - [31]=1 -> IDLE and set ConfigDone. SYNC_WORD itself has [31]=1, so it acts as a desync.
//    - Otherwise latch col and frame, set bad = (col>=NumColumns)||(frame>=MaxFramesPerCol),
//      clear the row counter, and go to DATA.
//  - DATA: Ready=1. The k-th accepted word (k = 0..NumRows-1) is written to row k of
//    FrameData, unless bad, in which case it is consumed and dropped.
//    After word NumRows-1: -> CHECK if CONFIG_CRC_EN, else -> STROBE.
//  - CHECK: only present when CONFIG_CRC_EN is defined; see CONFIGURATION.
//  - STROBE: lasts exactly 1 cycle with Ready=0.
//    - If !bad, FrameStrobe[col*MaxFramesPerCol+frame]=1 and all other bits are 0.
//    - If bad, no strobe is issued and ConfigError is set.
//    - Then -> HEADER.
//  Timing
//  - Strobe is high in the cycle after the last data/check word is accepted.
//  - FrameData holds stable from the strobe cycle until the next packet's row 0 is written.
//  - WriteStrobe low stalls any Ready state indefinitely with no state change.
//  - Throughput: NumRows+2 cycles per packet (+1 with CONFIG_CRC_EN).
//  - FrameStrobe is never multi-hot and is 0 in every state except STROBE.
// CONFIGURATION
//  CONFIG_CRC_EN defined
//  - A CHECK word follows the data words and must equal the XOR of all NumRows data words.
//  - On mismatch, bad is set: no strobe is issued and ConfigError is set. Row data
//    already written stays in FrameData.
//  CONFIG_CRC_EN undefined
//  - There is no CHECK state and no check word; packets are 1+NumRows words long.
// STRUCTURE
//  frame_config_pkg
//  - State enum (IDLE, HEADER, DATA, CHECK, STROBE).
//  - SYNC_WORD default.
//  - Header field positions: DESYNC_BIT=31, COL_LSB=12, COL_W=8, FRAME_LSB=0, FRAME_W=5.
//  frame_strobe_decoder (sub-module)
//  - Combinational one-hot decode of (col, frame, en) to the FrameStrobe vector; en=0 gives all 0.
//  - Registered in the parent.
//  Top level holds the FSM, row counter, FrameData registers and XOR accumulator.
// TESTING
//  1. Reset, then the stream FAB0FAB1, 0x0000_3002, 16 words 0x1000_0000+k
//     -> row k = 0x1000_0000+k, FrameStrobe bit 62 high for 1 cycle, Ready=0 in that cycle.
//  2. Garbage 0xDEADBEEF x3 then sync -> garbage ignored, ConfigBusy rises only after sync.
//  3. Header col=16, frame=0 (or frame=20) -> 16 words consumed, no strobe, ConfigError=1;
//     the next valid packet still strobes.
//  4. Random WriteStrobe gaps during DATA -> identical FrameData/strobe to the gapless run.
//  5. RESET at data word 7 -> no strobe; outputs at reset values; new sync + packet succeeds.
//  6. Header 0x8000_0000 -> ConfigDone=1 and IDLE; with CONFIG_CRC_EN, a wrong check word
//     -> no strobe and ConfigError=1.

Source files
------------

// File: rtl/frame_config_pkg.sv
// Shared types and header-field layout for the frame configuration sequencer.
// Used by the top-level sequencer and the strobe decoder.
package frame_config_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_CHECK,
    ST_STROBE
  } state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

  localparam int DESYNC_BIT = 31;
  localparam int COL_LSB    = 12;
  localparam int COL_W      = 8;
  localparam int FRAME_LSB  = 0;
  localparam int FRAME_W    = 5;

  // A header is unusable when it addresses a column or frame that does not exist.
  function automatic logic hdr_bad(input logic [31:0] hdr,
                                   input int num_cols,
                                   input int max_frames);
    return (int'(hdr[COL_LSB +: COL_W]) >= num_cols) ||
           (int'(hdr[FRAME_LSB +: FRAME_W]) >= max_frames);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Combinational one-hot decode of (col, frame) into the flat FrameStrobe vector.
// Out-of-range addresses or en=0 produce an all-zero vector.
module frame_strobe_decoder
  import frame_config_pkg::*;
#(
  parameter int NumColumns      = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [COL_W-1:0]                      col,
  input  logic [FRAME_W-1:0]                    frame,
  input  logic                                  en,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  localparam int SW = NumColumns * MaxFramesPerCol;

  logic [15:0] idx;
  logic        in_range;

  always_comb begin
    idx      = 16'(col) * 16'(MaxFramesPerCol) + 16'(frame);
    in_range = (int'(col) < NumColumns) && (int'(frame) < MaxFramesPerCol);
    strobe   = '0;
    if (en && in_range) begin
      strobe = SW'(1) << idx;
    end
  end

endmodule

// File: rtl/frame_config_sequencer.sv
// Bitstream-to-frame sequencer: hunts for sync, parses header/data packets, strobes one frame.
// Optional build macro CONFIG_CRC_EN adds an XOR check word after the data words.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | discarding words until SYNC_WORD is accepted
// ST_HEADER | waiting for a header word (bit 31 set = desync back to IDLE)
// ST_DATA   | writing NumRows data words into FrameData rows 0..NumRows-1
// ST_CHECK  | (CONFIG_CRC_EN only) comparing the check word with the XOR of data
// ST_STROBE | single cycle, Ready=0, FrameStrobe pulses unless packet is bad
module frame_config_sequencer
  import frame_config_pkg::*;
#(
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumRows         = 16,
  parameter int          NumColumns      = 16,
  parameter logic [31:0] SYNC_WORD       = SYNC_WORD_DEFAULT
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [31:0]                           WriteData,
  input  logic                                  WriteStrobe,
  output logic                                  Ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  ConfigBusy,
  output logic                                  ConfigDone,
  output logic                                  ConfigError
);

  localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_t                                      state_q, state_d;
  logic [COL_W-1:0]                            col_q;
  logic [FRAME_W-1:0]                          frame_q;
  logic                                        bad_q, bad_d;
  logic [ROW_W-1:0]                            row_cnt_q;
  logic [NumRows-1:0][FrameBitsPerRow-1:0]     rows_q;
  logic [NumColumns*MaxFramesPerCol-1:0]       strobe_q, strobe_d;
  logic                                        done_q, error_q;
  logic                                        accept, is_sync, is_desync, last_row;
`ifdef CONFIG_CRC_EN
  logic [31:0]                                 crc_q;
`endif

  assign Ready       = (state_q != ST_STROBE);
  assign accept      = WriteStrobe && Ready;
  assign is_sync     = (WriteData == SYNC_WORD);
  assign is_desync   = WriteData[DESYNC_BIT];
  assign last_row    = (row_cnt_q == ROW_W'(NumRows - 1));

  assign FrameData   = rows_q;
  assign FrameStrobe = strobe_q;
  assign ConfigBusy  = (state_q != ST_IDLE);
  assign ConfigDone  = done_q;
  assign ConfigError = error_q;

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_sync) begin
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          if (is_desync) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bad_d   = hdr_bad(WriteData, NumColumns, MaxFramesPerCol);
          end
        end
      end
      ST_DATA: begin
        if (accept && last_row) begin
`ifdef CONFIG_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_STROBE;
`endif
        end
      end
`ifdef CONFIG_CRC_EN
      ST_CHECK: begin
        if (accept) begin
          state_d = ST_STROBE;
          bad_d   = bad_q || (WriteData != crc_q);
        end
      end
`endif
      ST_STROBE: begin
        state_d = ST_HEADER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decoded one cycle early so the registered strobe lines up with ST_STROBE.
  frame_strobe_decoder #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_strobe_dec (
    .col    (col_q),
    .frame  (frame_q),
    .en     ((state_d == ST_STROBE) && !bad_d),
    .strobe (strobe_d)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      frame_q   <= '0;
      bad_q     <= 1'b0;
      row_cnt_q <= '0;
      rows_q    <= '0;
      strobe_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef CONFIG_CRC_EN
      crc_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      bad_q    <= bad_d;
      strobe_q <= strobe_d;
      if (state_q == ST_STROBE && bad_q) begin
        error_q <= 1'b1;
      end
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (is_sync) begin
              done_q  <= 1'b0;
              error_q <= 1'b0;
            end
          end
          ST_HEADER: begin
            if (is_desync) begin
              done_q <= 1'b1;
            end else begin
              col_q     <= WriteData[COL_LSB +: COL_W];
              frame_q   <= WriteData[FRAME_LSB +: FRAME_W];
              row_cnt_q <= '0;
`ifdef CONFIG_CRC_EN
              crc_q     <= '0;
`endif
            end
          end
          ST_DATA: begin
            // Bad packets are still consumed so the stream stays aligned.
            if (!bad_q) begin
              rows_q[row_cnt_q] <= WriteData;
            end
            row_cnt_q <= row_cnt_q + ROW_W'(1);
`ifdef CONFIG_CRC_EN
            crc_q     <= crc_q ^ WriteData;
`endif
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Scoreboard bench for frame_config_sequencer: packet-level model pushes expectations,
// a negedge monitor checks every strobe cycle. Honours CONFIG_CRC_EN like the RTL.
module tb_frame_config_sequencer;

  localparam int          NR   = 16;
  localparam int          NC   = 16;
  localparam int          MF   = 20;
  localparam int          FDW  = NR * 32;
  localparam int          FSW  = NC * MF;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [31:0]    WriteData;
  logic           WriteStrobe;
  logic           Ready;
  logic [FDW-1:0] FrameData;
  logic [FSW-1:0] FrameStrobe;
  logic           ConfigBusy, ConfigDone, ConfigError;

  frame_config_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .WriteData   (WriteData),
    .WriteStrobe (WriteStrobe),
    .Ready       (Ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .ConfigBusy  (ConfigBusy),
    .ConfigDone  (ConfigDone),
    .ConfigError (ConfigError)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int             idx;
    logic [FDW-1:0] data;
    bit             err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_rows[NR];
  bit          m_err;
  int          n_vec = 0;
  int          n_err = 0;
  bit          err_pending = 1'b0;
  bit          err_exp;

  task automatic chk(input string name, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FDW-1:0] model_data();
    logic [FDW-1:0] d;
    for (int r = 0; r < NR; r++) d[r*32 +: 32] = m_rows[r];
    return d;
  endfunction

  // Called and returns just after a falling edge; the word is taken on the edge Ready is seen high.
  task automatic send_word(input logic [31:0] w, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        WriteStrobe = 1'b0;
        WriteData   = $urandom;
        @(negedge CLK);
      end
    end
    WriteData   = w;
    WriteStrobe = 1'b1;
    guard       = 0;
    while (Ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: Ready stuck at %b, required 1", Ready);
    end
    @(negedge CLK);
    WriteStrobe = 1'b0;
  endtask

  task automatic send_packet(input int col, input int frame, input bit gaps,
                             input bit crc_bad, input bit rnd, input logic [31:0] base);
    logic [31:0] words[NR];
    logic [31:0] x;
    bit          bad;
    exp_t        e;
    x   = '0;
    bad = (col >= NC) || (frame >= MF);
    for (int k = 0; k < NR; k++) begin
      words[k] = rnd ? $urandom : base + 32'(k);
      x ^= words[k];
    end
    if (!bad) for (int k = 0; k < NR; k++) m_rows[k] = words[k];
`ifdef CONFIG_CRC_EN
    if (crc_bad) bad = 1'b1;
`endif
    if (bad) m_err = 1'b1;
    e.idx  = bad ? -1 : col * MF + frame;
    e.data = model_data();
    e.err  = m_err;
    sb_q.push_back(e);
    send_word((32'(col) << 12) | 32'(frame), gaps);
    for (int k = 0; k < NR; k++) send_word(words[k], gaps);
`ifdef CONFIG_CRC_EN
    send_word(crc_bad ? ~x : x, gaps);
`endif
  endtask

  always @(negedge CLK) begin
    exp_t           e;
    logic [FSW-1:0] exp_fs;
    if (RESET === 1'b0) begin
      if (err_pending) begin
        chk("error_after_strobe", FDW'(ConfigError), FDW'(err_exp));
        err_pending = 1'b0;
      end
      if (Ready === 1'b0) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe_cycle: FrameStrobe %0h, required no strobe cycle", FrameStrobe);
        end else begin
          e      = sb_q.pop_front();
          exp_fs = (e.idx < 0) ? '0 : (FSW'(1) << e.idx);
          chk("strobe_vector", FDW'(FrameStrobe), FDW'(exp_fs));
          chk("frame_data", FrameData, e.data);
          err_pending = 1'b1;
          err_exp     = e.err;
        end
      end else begin
        chk("strobe_idle_zero", FDW'(FrameStrobe), '0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    RESET       = 1'b1;
    WriteStrobe = 1'b0;
    WriteData   = '0;
    m_err       = 1'b0;
    for (int r = 0; r < NR; r++) m_rows[r] = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", FDW'(Ready), FDW'(1));
    chk("rst_busy", FDW'(ConfigBusy), FDW'(0));
    chk("rst_done", FDW'(ConfigDone), FDW'(0));
    chk("rst_error", FDW'(ConfigError), FDW'(0));
    chk("rst_framedata", FrameData, '0);
    chk("rst_strobe", FDW'(FrameStrobe), '0);
    RESET = 1'b0;
    @(negedge CLK);

    // Basic packet: column 3, frame 2.
    send_word(SYNC, 1'b0);
    chk("busy_after_sync", FDW'(ConfigBusy), FDW'(1));
    send_packet(3, 2, 1'b0, 1'b0, 1'b0, 32'h1000_0000);

    // Desync header.
    send_word(32'h8000_0000, 1'b0);
    chk("desync_done", FDW'(ConfigDone), FDW'(1));
    chk("desync_idle", FDW'(ConfigBusy), FDW'(0));

    // Garbage in IDLE is ignored.
    for (int i = 0; i < 3; i++) begin
      send_word(32'hDEAD_BEEF, 1'b0);
      chk("garbage_not_busy", FDW'(ConfigBusy), FDW'(0));
    end
    send_word(SYNC, 1'b0);
    m_err = 1'b0;
    chk("resync_busy", FDW'(ConfigBusy), FDW'(1));
    chk("resync_done_clr", FDW'(ConfigDone), FDW'(0));

    // Out-of-range addresses, then the extreme valid corners.
    send_packet(16, 0, 1'b0, 1'b0, 1'b1, '0);
    send_packet(0, 20, 1'b0, 1'b0, 1'b1, '0);
    send_packet(15, 19, 1'b0, 1'b0, 1'b1, '0);
    send_packet(0, 0, 1'b0, 1'b0, 1'b1, '0);

    // Same packet gapless and with random WriteStrobe gaps.
    base = $urandom;
    send_packet(7, 11, 1'b0, 1'b0, 1'b0, base);
    send_packet(7, 11, 1'b1, 1'b0, 1'b0, base);

`ifdef CONFIG_CRC_EN
    send_packet(2, 3, 1'b0, 1'b1, 1'b1, '0);
`endif

    for (int i = 0; i < 20; i++) begin
      send_packet($urandom_range(0, 17), $urandom_range(0, 21), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), 1'b1, '0);
    end

    // Reset in the middle of a packet.
    send_word((32'd5 << 12) | 32'd7, 1'b0);
    for (int k = 0; k < 7; k++) send_word($urandom, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_ready", FDW'(Ready), FDW'(1));
    chk("midrst_busy", FDW'(ConfigBusy), FDW'(0));
    chk("midrst_error", FDW'(ConfigError), FDW'(0));
    chk("midrst_done", FDW'(ConfigDone), FDW'(0));
    chk("midrst_framedata", FrameData, '0);
    chk("midrst_strobe", FDW'(FrameStrobe), '0);
    RESET = 1'b0;
    m_err = 1'b0;
    for (int r = 0; r < NR; r++) m_rows[r] = '0;
    @(negedge CLK);
    send_word(SYNC, 1'b0);
    send_packet(5, 7, 1'b1, 1'b0, 1'b1, '0);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", FDW'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
